// File: rtl/count_display_pkg.sv
// Shared types and helpers for the BCD count display: FSM states, 7-segment
// codes (active-high, bit0=a .. bit6=g) and the double-dabble digit adjust.
package count_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Non-decimal nibbles cannot occur; they map to blank rather than garbage.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [11:0] bcd_adjust(input logic [11:0] w);
    logic [11:0] r;
    r = w;
    for (int i = 0; i < 3; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit to 3-digit BCD converter (shift-add-3), one shift per clock.
// done marks the edge of the final shift; dout is the result from then on.
module bin2bcd_seq
  import count_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  din,
  output logic [11:0] dout,
  output logic        done
);

  logic [7:0]  sh_q, sh_d;
  logic [11:0] w_q, w_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        run_q, run_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    sh_d  = sh_q;
    w_d   = w_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      sh_d  = din;
      w_d   = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      {w_d, sh_d} = {bcd_adjust(w_q), sh_q} << 1;
      cnt_d       = cnt_q + 3'd1;
      if (cnt_q == 3'd7) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    if (reset) begin
      sh_q  <= '0;
      w_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign dout = w_q;
  assign done = run_q && (cnt_q == 3'd7);

endmodule

// File: rtl/count_bcd_display.sv
// Samples the counter value, converts it to BCD when it changes and drives
// three registered 7-segment digits with optional leading-zero blanking.
module count_bcd_display
  import count_display_pkg::*;
#(
  parameter logic BLANK_LZ       = 1'b1,
  parameter logic SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  count,
  output logic [11:0] bcd,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic        busy,
  output logic        upd
);

  // XOR mask applied to every active-high code to reach board polarity.
  localparam logic [6:0] SEG_POL    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_LZ_RST = BLANK_LZ ? SEG_BLANK : SEG_0;

  state_e      state_q;
  logic [7:0]  last_q;
  logic        force_q;
  logic [11:0] bcd_q;
  logic [6:0]  hex2_q, hex1_q, hex0_q;
  logic        upd_q;

  logic        start;
  logic [11:0] conv_w;
  logic        conv_done;
  logic [6:0]  hex2_d, hex1_d, hex0_d;

  assign start = (state_q == IDLE) && ((count != last_q) || force_q);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .din   (count),
    .dout  (conv_w),
    .done  (conv_done)
  );

  always_comb begin
    hex2_d = digit_to_seg(conv_w[11:8]);
    hex1_d = digit_to_seg(conv_w[7:4]);
    hex0_d = digit_to_seg(conv_w[3:0]);
    if (BLANK_LZ && (conv_w[11:8] == 4'd0)) begin
      hex2_d = SEG_BLANK;
      if (conv_w[7:4] == 4'd0) hex1_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= '0;
      force_q <= 1'b1;
      bcd_q   <= '0;
      hex2_q  <= SEG_LZ_RST ^ SEG_POL;
      hex1_q  <= SEG_LZ_RST ^ SEG_POL;
      hex0_q  <= SEG_0 ^ SEG_POL;
      upd_q   <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            last_q  <= count;
            force_q <= 1'b0;
            state_q <= CONV;
          end
        end
        CONV: begin
          if (conv_done) state_q <= UPDATE;
        end
        UPDATE: begin
          bcd_q   <= conv_w;
          hex2_q  <= hex2_d ^ SEG_POL;
          hex1_q  <= hex1_d ^ SEG_POL;
          hex0_q  <= hex0_d ^ SEG_POL;
          upd_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign hex2 = hex2_q;
  assign hex1 = hex1_q;
  assign hex0 = hex0_q;
  assign upd  = upd_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_count_bcd_display.sv
// Bench for count_bcd_display: two instances (blanking/active-low and
// no-blanking/active-high) compared against an arithmetic reference model.
module tb_count_bcd_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] count;

  logic [11:0] a_bcd, b_bcd;
  logic [6:0]  a_hex2, a_hex1, a_hex0, b_hex2, b_hex1, b_hex0;
  logic        a_busy, a_upd, b_busy, b_upd;

  always #5 clk = ~clk;

  count_bcd_display #(.BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset(reset), .count(count), .bcd(a_bcd),
    .hex2(a_hex2), .hex1(a_hex1), .hex0(a_hex0), .busy(a_busy), .upd(a_upd)
  );

  count_bcd_display #(.BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .reset(reset), .count(count), .bcd(b_bcd),
    .hex2(b_hex2), .hex1(b_hex1), .hex0(b_hex0), .busy(b_busy), .upd(b_upd)
  );

  // Posedges from the negedge before the sample edge until upd is visible:
  // the sample edge itself plus nine more.
  localparam int LAT = 10;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] ref_hex(input int v, input bit blank_lz, input bit active_low);
    int h, t, u;
    logic [6:0] s2, s1, s0;
    h  = v / 100;
    t  = (v / 10) % 10;
    u  = v % 10;
    s2 = (blank_lz && h == 0) ? 7'h00 : seg_of(h);
    s1 = (blank_lz && h == 0 && t == 0) ? 7'h00 : seg_of(t);
    s0 = seg_of(u);
    if (active_low) return {~s2, ~s1, ~s0};
    return {s2, s1, s0};
  endfunction

  task automatic check_display(input string tag, input int v);
    logic [20:0] ea, eb;
    ea = ref_hex(v, 1'b1, 1'b1);
    eb = ref_hex(v, 1'b0, 1'b0);
    check({tag, " a_bcd"},  32'(a_bcd),  32'(ref_bcd(v)));
    check({tag, " a_hex2"}, 32'(a_hex2), 32'(ea[20:14]));
    check({tag, " a_hex1"}, 32'(a_hex1), 32'(ea[13:7]));
    check({tag, " a_hex0"}, 32'(a_hex0), 32'(ea[6:0]));
    check({tag, " b_bcd"},  32'(b_bcd),  32'(ref_bcd(v)));
    check({tag, " b_hex"},  32'({b_hex2, b_hex1, b_hex0}), 32'(eb));
  endtask

  // Starts at a negedge; returns the number of posedges until upd is seen (bounded).
  task automatic wait_upd(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end while (!a_upd && edges < 40);
  endtask

  typedef struct {
    logic [7:0]  cnt;
    logic [11:0] bcd;
    logic [6:0]  h2, h1, h0;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, extra, prev, v, n_upd;
    bit saw_zero;
    logic [7:0] hist[65];

    // Expected values for the blanking, active-low instance.
    vecs[0] = '{8'd7,   12'h007, 7'h7F, 7'h7F, 7'h78};
    vecs[1] = '{8'd255, 12'h255, 7'h24, 7'h12, 7'h12};
    vecs[2] = '{8'd10,  12'h010, 7'h7F, 7'h79, 7'h40};
    vecs[3] = '{8'd99,  12'h099, 7'h7F, 7'h10, 7'h10};
    vecs[4] = '{8'd200, 12'h200, 7'h24, 7'h40, 7'h40};
    vecs[5] = '{8'd105, 12'h105, 7'h79, 7'h40, 7'h12};
    vecs[6] = '{8'd0,   12'h000, 7'h7F, 7'h7F, 7'h40};

    // Reset state, then the forced first conversion of 0.
    reset = 1'b1;
    count = 8'd0;
    repeat (3) @(negedge clk);
    check("rst a_bcd",  32'(a_bcd),  32'h000);
    check("rst a_hex2", 32'(a_hex2), 32'h7F);
    check("rst a_hex1", 32'(a_hex1), 32'h7F);
    check("rst a_hex0", 32'(a_hex0), 32'h40);
    check("rst a_busy", 32'(a_busy), 32'd0);
    check("rst a_upd",  32'(a_upd),  32'd0);
    check("rst b_hex",  32'({b_hex2, b_hex1, b_hex0}), 32'({7'h3F, 7'h3F, 7'h3F}));
    reset = 1'b0;
    wait_upd(e);
    check("rst forced latency", 32'(e), 32'(LAT));
    check_display("rst zero", 0);
    extra = 0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (a_upd) extra++;
    end
    check("rst single upd", 32'(extra), 32'd0);
    check("rst idle busy", 32'(a_busy), 32'd0);

    // Held values from the table.
    for (int i = 0; i < 7; i++) begin
      count = vecs[i].cnt;
      wait_upd(e);
      check($sformatf("vec%0d latency", i), 32'(e), 32'(LAT));
      check($sformatf("vec%0d bcd", i),  32'(a_bcd),  32'(vecs[i].bcd));
      check($sformatf("vec%0d hex2", i), 32'(a_hex2), 32'(vecs[i].h2));
      check($sformatf("vec%0d hex1", i), 32'(a_hex1), 32'(vecs[i].h1));
      check($sformatf("vec%0d hex0", i), 32'(a_hex0), 32'(vecs[i].h0));
      check($sformatf("vec%0d b_hex", i), 32'({b_hex2, b_hex1, b_hex0}),
            32'(ref_hex(int'(vecs[i].cnt), 1'b0, 1'b0)));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d upd pulse", i), 32'(a_upd), 32'd0);
    end

    // Count changes mid-conversion: old value finishes, new one follows.
    count = 8'd10;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midconv busy", 32'(a_busy), 32'd1);
    check("midconv bcd held", 32'(a_bcd), 32'h000);
    count = 8'd99;
    wait_upd(e);
    check("midconv first latency", 32'(e + 3), 32'(LAT));
    check_display("midconv first", 10);
    wait_upd(e);
    check("midconv second latency", 32'(e), 32'(LAT));
    check_display("midconv second", 99);

    // Reset during the 4th CONV cycle of a conversion of 200.
    count = 8'd200;
    extra = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (a_upd) extra++;
    end
    check("abort busy before", 32'(a_busy), 32'd1);
    reset = 1'b1;
    count = 8'd150;
    @(posedge clk);
    @(negedge clk);
    if (a_upd) extra++;
    check("abort no upd", 32'(extra), 32'd0);
    check("abort busy", 32'(a_busy), 32'd0);
    check("abort a_bcd", 32'(a_bcd), 32'h000);
    check("abort a_hex", 32'({a_hex2, a_hex1, a_hex0}), 32'({7'h7F, 7'h7F, 7'h40}));
    check("abort b_hex", 32'({b_hex2, b_hex1, b_hex0}), 32'({7'h3F, 7'h3F, 7'h3F}));
    @(negedge clk);
    reset = 1'b0;
    wait_upd(e);
    check("abort release latency", 32'(e), 32'(LAT));
    check_display("abort release", 150);

    // Randomised held values.
    prev = 150;
    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 255));
      if (v == prev) v = (v + 1) % 256;
      count = 8'(v);
      wait_upd(e);
      check($sformatf("rand%0d latency", i), 32'(e), 32'(LAT));
      check_display($sformatf("rand%0d v=%0d", i, v), v);
      prev = v;
    end
    if (prev == 246) begin
      count = 8'd1;
      wait_upd(e);
      check("prefree latency", 32'(e), 32'(LAT));
    end

    // Free-running counter across the 255->0 wrap.
    n_upd    = 0;
    saw_zero = 1'b0;
    for (int k = 0; k < 65; k++) begin
      count   = 8'(246 + k);
      hist[k] = count;
      @(posedge clk);
      @(negedge clk);
      if (a_upd) begin
        n_upd++;
        if (k >= 9) begin
          check_display($sformatf("free edge%0d", k), int'(hist[k - 9]));
          if (hist[k - 9] == 8'd0) saw_zero = 1'b1;
        end else begin
          check("free early upd", 32'(k), 32'd9);
        end
        check("free nibble range",
              32'((a_bcd[11:8] <= 4'd2) && (a_bcd[7:4] <= 4'd9) && (a_bcd[3:0] <= 4'd9)), 32'd1);
      end
    end
    check("free upd count", 32'(n_upd), 32'd6);
    check("free wrap zero shown", 32'(saw_zero), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
